ide_disk_arbiter: RTL and testbench

- Shares one single-block IDE disk engine between two requesters, e.g. the RF08 and DF32 disk controllers. The engine transfers one 256-word block per request.
- Round-robin arbitration; the grant is held for a whole block transfer.
- Latches the LBA and direction, routes the engine's 12-bit buffer port to the granted requester, and returns done/error to that requester only.
- Includes a watchdog that resets the engine if a transfer hangs.

---
 rtl/ide_disk_arbiter_if.sv | 53 +++++
 rtl/ide_disk_arbiter.sv | 141 ++++++++++++++
 tb/tb_ide_disk_arbiter.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ide_disk_arbiter_if.sv
// Signal bundle for ide_disk_arbiter: two block requesters plus the shared disk engine.
// The slave modport is the arbiter's view; master is the requester/engine side.
interface ide_disk_arbiter_if;
  logic        rq0_read_req,    rq1_read_req;
  logic        rq0_write_req,   rq1_write_req;
  logic [23:0] rq0_lba,         rq1_lba;
  logic        rq0_done,        rq1_done;
  logic        rq0_error,       rq1_error;
  logic [7:0]  rq0_buffer_addr, rq1_buffer_addr;
  logic        rq0_buffer_rd,   rq1_buffer_rd;
  logic        rq0_buffer_wr,   rq1_buffer_wr;
  logic [11:0] rq0_buffer_out,  rq1_buffer_out;
  logic [11:0] rq0_buffer_in,   rq1_buffer_in;

  logic [23:0] disk_lba;
  logic        disk_read_req;
  logic        disk_write_req;
  logic        disk_reset;
  logic        disk_done;
  logic        disk_error;
  logic [7:0]  disk_buffer_addr;
  logic        disk_buffer_rd;
  logic        disk_buffer_wr;
  logic [11:0] disk_buffer_out;
  logic [11:0] disk_buffer_in;

  logic        grant;
  logic        busy;

  modport slave (
    input  rq0_read_req, rq1_read_req, rq0_write_req, rq1_write_req,
    input  rq0_lba, rq1_lba, rq0_buffer_in, rq1_buffer_in,
    output rq0_done, rq1_done, rq0_error, rq1_error,
    output rq0_buffer_addr, rq1_buffer_addr, rq0_buffer_rd, rq1_buffer_rd,
    output rq0_buffer_wr, rq1_buffer_wr, rq0_buffer_out, rq1_buffer_out,
    output disk_lba, disk_read_req, disk_write_req, disk_reset, disk_buffer_in,
    input  disk_done, disk_error, disk_buffer_addr, disk_buffer_rd, disk_buffer_wr,
    input  disk_buffer_out,
    output grant, busy
  );

  modport master (
    output rq0_read_req, rq1_read_req, rq0_write_req, rq1_write_req,
    output rq0_lba, rq1_lba, rq0_buffer_in, rq1_buffer_in,
    input  rq0_done, rq1_done, rq0_error, rq1_error,
    input  rq0_buffer_addr, rq1_buffer_addr, rq0_buffer_rd, rq1_buffer_rd,
    input  rq0_buffer_wr, rq1_buffer_wr, rq0_buffer_out, rq1_buffer_out,
    input  disk_lba, disk_read_req, disk_write_req, disk_reset, disk_buffer_in,
    output disk_done, disk_error, disk_buffer_addr, disk_buffer_rd, disk_buffer_wr,
    output disk_buffer_out,
    input  grant, busy
  );
endinterface

// File: rtl/ide_disk_arbiter.sv
// Round-robin sharing of one single-block IDE disk engine between two requesters,
// with a watchdog that resets the engine when a transfer hangs.
module ide_disk_arbiter #(
  parameter logic [23:0] TIMEOUT    = 24'd10000000,
  parameter int          RST_CYCLES = 4
) (
  input logic               clk,
  input logic               reset,
  ide_disk_arbiter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESET, S_DRAIN} state_t;

  localparam logic [23:0] RST_LAST = 24'(RST_CYCLES - 1);

  state_t      state;
  logic [23:0] count;
  logic [23:0] lba_q;
  logic        grant_q;
  logic        busy_q;
  logic        rd_req_q;
  logic        wr_req_q;
  logic        disk_reset_q;
  logic [1:0]  done_q;
  logic [1:0]  error_q;

  logic pend0, pend1, winner, win_write;

  assign pend0 = bus.rq0_read_req | bus.rq0_write_req;
  assign pend1 = bus.rq1_read_req | bus.rq1_write_req;
  // On a tie the port that did not hold the last grant wins, which also keeps a
  // requester that is slow to drop its request from starving the other one.
  assign winner    = (pend0 & pend1) ? ~grant_q : pend1;
  assign win_write = winner ? bus.rq1_write_req : bus.rq0_write_req;

  // NOTE: every register below uses <= so all of them update from the same
  // pre-edge values; a blocking = here would let later lines see new state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      count        <= '0;
      lba_q        <= '0;
      grant_q      <= 1'b1;
      busy_q       <= 1'b0;
      rd_req_q     <= 1'b0;
      wr_req_q     <= 1'b0;
      disk_reset_q <= 1'b0;
      done_q       <= '0;
      error_q      <= '0;
    end else begin
      done_q <= '0;
      case (state)
        S_IDLE: begin
          if (pend0 | pend1) begin
            grant_q  <= winner;
            lba_q    <= winner ? bus.rq1_lba : bus.rq0_lba;
            rd_req_q <= ~win_write;
            wr_req_q <= win_write;
            count    <= '0;
            busy_q   <= 1'b1;
            state    <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (bus.disk_done) begin
            done_q[grant_q]  <= 1'b1;
            error_q[grant_q] <= bus.disk_error;
            rd_req_q         <= 1'b0;
            wr_req_q         <= 1'b0;
            state            <= S_DRAIN;
          end else if (count == TIMEOUT - 24'd1) begin
            done_q[grant_q]  <= 1'b1;
            error_q[grant_q] <= 1'b1;
            rd_req_q         <= 1'b0;
            wr_req_q         <= 1'b0;
            disk_reset_q     <= 1'b1;
            count            <= '0;
            state            <= S_RESET;
          end else begin
            count <= count + 24'd1;
          end
        end
        S_RESET: begin
          // The watchdog counter is reused to time the engine reset pulse.
          if (count == RST_LAST) begin
            disk_reset_q <= 1'b0;
            state        <= S_DRAIN;
          end else begin
            count <= count + 24'd1;
          end
        end
        S_DRAIN: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.grant          = grant_q;
  assign bus.busy           = busy_q;
  assign bus.disk_lba       = lba_q;
  assign bus.disk_read_req  = rd_req_q;
  assign bus.disk_write_req = wr_req_q;
  assign bus.disk_reset     = disk_reset_q;
  assign bus.rq0_done       = done_q[0];
  assign bus.rq1_done       = done_q[1];
  assign bus.rq0_error      = error_q[0];
  assign bus.rq1_error      = error_q[1];

  // NOTE: every output gets a default before the if, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    bus.rq0_buffer_addr = '0;
    bus.rq0_buffer_rd   = 1'b0;
    bus.rq0_buffer_wr   = 1'b0;
    bus.rq0_buffer_out  = '0;
    bus.rq1_buffer_addr = '0;
    bus.rq1_buffer_rd   = 1'b0;
    bus.rq1_buffer_wr   = 1'b0;
    bus.rq1_buffer_out  = '0;
    bus.disk_buffer_in  = '0;
    if (busy_q) begin
      if (grant_q) begin
        bus.rq1_buffer_addr = bus.disk_buffer_addr;
        bus.rq1_buffer_rd   = bus.disk_buffer_rd;
        bus.rq1_buffer_wr   = bus.disk_buffer_wr;
        bus.rq1_buffer_out  = bus.disk_buffer_out;
        bus.disk_buffer_in  = bus.rq1_buffer_in;
      end else begin
        bus.rq0_buffer_addr = bus.disk_buffer_addr;
        bus.rq0_buffer_rd   = bus.disk_buffer_rd;
        bus.rq0_buffer_wr   = bus.disk_buffer_wr;
        bus.rq0_buffer_out  = bus.disk_buffer_out;
        bus.disk_buffer_in  = bus.rq0_buffer_in;
      end
    end
  end

endmodule

// File: tb/tb_ide_disk_arbiter.sv
// Self-checking bench for ide_disk_arbiter: a bench-driven disk engine, random requests,
// and a transaction-level model of round-robin grants and per-port error status.
module tb_ide_disk_arbiter;

  localparam logic [23:0] TIMEOUT    = 24'd700;
  localparam int          RST_CYCLES = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  int   m_grant;
  logic m_err [2];

  ide_disk_arbiter_if bus ();

  ide_disk_arbiter #(.TIMEOUT(TIMEOUT), .RST_CYCLES(RST_CYCLES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic rq_done(input int p);
    return p != 0 ? bus.rq1_done : bus.rq0_done;
  endfunction
  function automatic logic rq_error(input int p);
    return p != 0 ? bus.rq1_error : bus.rq0_error;
  endfunction
  function automatic logic [7:0] rq_baddr(input int p);
    return p != 0 ? bus.rq1_buffer_addr : bus.rq0_buffer_addr;
  endfunction
  function automatic logic rq_brd(input int p);
    return p != 0 ? bus.rq1_buffer_rd : bus.rq0_buffer_rd;
  endfunction
  function automatic logic rq_bwr(input int p);
    return p != 0 ? bus.rq1_buffer_wr : bus.rq0_buffer_wr;
  endfunction
  function automatic logic [11:0] rq_bout(input int p);
    return p != 0 ? bus.rq1_buffer_out : bus.rq0_buffer_out;
  endfunction
  function automatic logic rq_pend(input int p);
    return p != 0 ? (bus.rq1_read_req | bus.rq1_write_req) : (bus.rq0_read_req | bus.rq0_write_req);
  endfunction
  function automatic logic rq_wr(input int p);
    return p != 0 ? bus.rq1_write_req : bus.rq0_write_req;
  endfunction
  function automatic logic [23:0] rq_lba(input int p);
    return p != 0 ? bus.rq1_lba : bus.rq0_lba;
  endfunction
  function automatic bit port_quiet(input int p);
    return rq_baddr(p) == 8'd0 && !rq_brd(p) && !rq_bwr(p) && rq_bout(p) == 12'd0 && !rq_done(p);
  endfunction

  task automatic set_req(input int p, input logic rd, input logic wr, input logic [23:0] lba);
    if (p != 0) begin
      bus.rq1_read_req = rd; bus.rq1_write_req = wr; bus.rq1_lba = lba;
    end else begin
      bus.rq0_read_req = rd; bus.rq0_write_req = wr; bus.rq0_lba = lba;
    end
  endtask

  // Spec rule: on a tie the port other than the last grant wins, else the lone pending port.
  function automatic int model_winner();
    if (rq_pend(0) && rq_pend(1)) return 1 - m_grant;
    return rq_pend(1) ? 1 : 0;
  endfunction

  task automatic wait_grant(output int waited);
    waited = 0;
    while (!(bus.disk_read_req | bus.disk_write_req) && waited < 20) begin
      @(negedge clk); #1;
      waited++;
    end
  endtask

  // One whole transfer: the engine moves nwords words, then signals done after latency cycles.
  task automatic do_transfer(input string tag, input int latency, input logic err,
                             input int nwords, input bit drop);
    int          w, waited, route_bad, other_bad, hold_bad, words;
    logic        wr_dir, strobe;
    logic [23:0] lba;
    logic [11:0] dout, bin [2];
    w      = model_winner();
    wr_dir = rq_wr(w);
    lba    = rq_lba(w);
    wait_grant(waited);
    check({tag, "_latency"}, waited, 1);
    check({tag, "_grant"}, bus.grant, w);
    check({tag, "_lba"}, bus.disk_lba, lba);
    check({tag, "_dir"}, {bus.disk_write_req, bus.disk_read_req}, {wr_dir, ~wr_dir});
    route_bad = 0; other_bad = 0; hold_bad = 0; words = 0;
    for (int c = 0; c < latency; c++) begin
      strobe               = (c < nwords);
      dout                 = 12'($urandom);
      bin[0]               = 12'($urandom);
      bin[1]               = 12'($urandom);
      bus.disk_buffer_addr = 8'(c);
      bus.disk_buffer_rd   = strobe & wr_dir;
      bus.disk_buffer_wr   = strobe & ~wr_dir;
      bus.disk_buffer_out  = dout;
      bus.rq0_buffer_in    = bin[0];
      bus.rq1_buffer_in    = bin[1];
      if (c == 3) set_req(w, rq_pend(w) & ~wr_dir, rq_pend(w) & wr_dir, 24'($urandom));
      #1;
      if (rq_baddr(w) !== 8'(c) || rq_brd(w) !== (strobe & wr_dir) ||
          rq_bwr(w) !== (strobe & ~wr_dir) || rq_bout(w) !== dout ||
          bus.disk_buffer_in !== bin[w]) route_bad++;
      if (rq_brd(w) | rq_bwr(w)) words++;
      if (!port_quiet(1 - w)) other_bad++;
      if ({bus.disk_write_req, bus.disk_read_req} !== {wr_dir, ~wr_dir} || bus.disk_lba !== lba ||
          bus.busy !== 1'b1 || rq_done(w) !== 1'b0 || bus.disk_reset !== 1'b0) hold_bad++;
      @(negedge clk);
    end
    check({tag, "_route"}, route_bad, 0);
    check({tag, "_other_quiet"}, other_bad, 0);
    check({tag, "_hold"}, hold_bad, 0);
    check({tag, "_words"}, words, nwords);
    bus.disk_buffer_rd = 1'b0; bus.disk_buffer_wr = 1'b0;
    bus.disk_buffer_addr = '0; bus.disk_buffer_out = '0;
    bus.disk_done = 1'b1; bus.disk_error = err;
    @(negedge clk);
    bus.disk_done = 1'b0; bus.disk_error = 1'($urandom);
    #1;
    check({tag, "_done"}, {rq_done(w), rq_done(1 - w)}, 2'b10);
    check({tag, "_err"}, {rq_error(w), rq_error(1 - w)}, {err, m_err[1 - w]});
    check({tag, "_drain"}, {bus.busy, bus.disk_read_req, bus.disk_write_req}, 3'b100);
    m_grant  = w;
    m_err[w] = err;
    if (drop) set_req(w, 1'b0, 1'b0, 24'($urandom));
    @(negedge clk); #1;
    check({tag, "_idle"}, {bus.busy, rq_done(0), rq_done(1)}, 3'b000);
  endtask

  initial begin
    int waited, lat, bad, pulses, rst_hi;
    m_grant = 1; m_err[0] = 1'b0; m_err[1] = 1'b0;
    set_req(0, 1'b0, 1'b0, '0);
    set_req(1, 1'b0, 1'b0, '0);
    bus.disk_done = 1'b0; bus.disk_error = 1'b0;
    bus.disk_buffer_addr = 8'hA5; bus.disk_buffer_rd = 1'b1; bus.disk_buffer_wr = 1'b1;
    bus.disk_buffer_out = 12'hFFF;
    bus.rq0_buffer_in = 12'h123; bus.rq1_buffer_in = 12'h456;

    // Reset state, with busy engine-side buffer traffic that must not reach any port.
    repeat (2) @(negedge clk);
    #1;
    check("rst_grant", bus.grant, 1);
    check("rst_regs", {bus.busy, bus.disk_read_req, bus.disk_write_req, bus.disk_reset,
                       bus.rq0_done, bus.rq1_done, bus.rq0_error, bus.rq1_error}, 8'h00);
    check("rst_lba", bus.disk_lba, 0);
    check("rst_quiet", {port_quiet(0), port_quiet(1)}, 2'b11);
    check("rst_buf_in", bus.disk_buffer_in, 0);
    bus.disk_buffer_rd = 1'b0; bus.disk_buffer_wr = 1'b0;
    reset = 1'b0;
    @(negedge clk); #1;

    // Simultaneous requests: port 0 read first, port 1 write next, then port 0 again.
    set_req(0, 1'b1, 1'b0, 24'h000123);
    set_req(1, 1'b0, 1'b1, 24'($urandom));
    do_transfer("p0_read", 600, 1'b0, 256, 1'b0);
    do_transfer("p1_write", 260, 1'b0, 256, 1'b1);
    do_transfer("p0_error", 40, 1'b1, 16, 1'b1);
    set_req(0, 1'b0, 1'b1, 24'($urandom));
    do_transfer("p0_clean", 30, 1'b0, 8, 1'b1);

    // Random traffic: random ports, directions (both set = write), LBAs, latencies, errors.
    for (int i = 0; i < 10; i++) begin
      for (int p = 0; p < 2; p++)
        if (!rq_pend(p) && $urandom_range(0, 1) == 1)
          set_req(p, 1'($urandom), 1'($urandom), 24'($urandom));
      if (!rq_pend(0) && !rq_pend(1))
        set_req(int'($urandom_range(0, 1)), 1'b1, 1'($urandom), 24'($urandom));
      lat = int'($urandom_range(5, 80));
      do_transfer("rand", lat, 1'($urandom), int'($urandom_range(0, lat)), 1'b1);
    end
    set_req(0, 1'b0, 1'b0, '0);
    set_req(1, 1'b0, 1'b0, '0);
    @(negedge clk); #1;

    // A stray engine completion while idle changes nothing.
    bus.disk_done = 1'b1; bus.disk_error = 1'b1;
    @(negedge clk);
    bus.disk_done = 1'b0; bus.disk_error = 1'b0;
    #1;
    check("stray_done", {bus.busy, bus.rq0_done, bus.rq1_done}, 3'b000);
    check("stray_err", {bus.rq0_error, bus.rq1_error}, {m_err[0], m_err[1]});

    // Watchdog: the engine never completes a port 0 read.
    set_req(0, 1'b1, 1'b0, 24'h00ABCD);
    wait_grant(waited);
    check("wd_latency", waited, 1);
    bad = 0;
    for (int c = 1; c <= int'(TIMEOUT); c++) begin
      if (bus.rq0_done !== 1'b0 || bus.disk_reset !== 1'b0 || bus.disk_read_req !== 1'b1) bad++;
      @(negedge clk); #1;
    end
    check("wd_no_early_done", bad, 0);
    check("wd_done", {bus.rq0_done, bus.rq1_done, bus.rq0_error, bus.rq1_error},
          {2'b10, 1'b1, m_err[1]});
    check("wd_reqs_low", {bus.disk_read_req, bus.disk_write_req, bus.busy}, 3'b001);
    m_grant = 0; m_err[0] = 1'b1;
    set_req(0, 1'b0, 1'b0, '0);
    rst_hi = 0;
    while (bus.disk_reset === 1'b1 && rst_hi < 20) begin
      rst_hi++;
      @(negedge clk); #1;
    end
    check("wd_reset_len", rst_hi, RST_CYCLES);
    check("wd_drain", {bus.busy, bus.rq0_done}, 2'b10);
    @(negedge clk); #1;
    check("wd_idle", bus.busy, 0);
    set_req(1, 1'b0, 1'b1, 24'($urandom));
    do_transfer("after_wd", 20, 1'b0, 10, 1'b1);

    // System reset in the middle of a transfer.
    set_req(1, 1'b1, 1'b0, 24'($urandom));
    wait_grant(waited);
    check("mid_latency", waited, 1);
    repeat (5) @(negedge clk);
    #1;
    reset = 1'b1;
    bus.disk_done = 1'b1;
    set_req(0, 1'b0, 1'b0, '0);
    set_req(1, 1'b0, 1'b0, '0);
    #1;
    check("mid_rst_regs", {bus.disk_read_req, bus.disk_write_req, bus.busy,
                           bus.rq0_done, bus.rq1_done, bus.rq0_error, bus.rq1_error}, 7'h00);
    check("mid_rst_grant", bus.grant, 1);
    check("mid_rst_quiet", {port_quiet(0), port_quiet(1)}, 2'b11);
    m_grant = 1; m_err[0] = 1'b0; m_err[1] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    bus.disk_done = 1'b0;
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      if (bus.rq0_done | bus.rq1_done | bus.busy) pulses++;
    end
    check("mid_no_done", pulses, 0);
    set_req(1, 1'b0, 1'b1, 24'($urandom));
    do_transfer("after_rst", 25, 1'b0, 12, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
